// File: rtl/kd_node_ctrl.sv
// k-d tree node controller: configures/sorts its subtree and checks child split ordering on its axis.
// Optional watchdog on child handshakes: define KD_NODE_TIMEOUT_EN.
module kd_node_ctrl #(
  parameter int DIM     = 2,
  parameter int COORD_W = 16,
  parameter int DEPTH_W = 4,
  parameter int CMD_W   = 3,
  parameter int TIMEOUT = 1023,
  localparam int DATA_W = DIM * COORD_W,
  localparam int AXIS_W = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CMD_W-1:0]   command_from_top,
  input  logic [CMD_W-1:0]   command_from_left,
  input  logic [CMD_W-1:0]   command_from_right,
  input  logic [DATA_W-1:0]  data_from_top,
  input  logic [DATA_W-1:0]  data_from_left,
  input  logic [DATA_W-1:0]  data_from_right,
  output logic [CMD_W-1:0]   command_to_top,
  output logic [CMD_W-1:0]   command_to_left,
  output logic [CMD_W-1:0]   command_to_right,
  output logic [DATA_W-1:0]  data_to_top,
  output logic [DATA_W-1:0]  data_to_left,
  output logic [DATA_W-1:0]  data_to_right,
  output logic [DEPTH_W-1:0] depth,
  output logic [AXIS_W-1:0]  axis,
  output logic               is_leaf,
  output logic               order_ok,
  output logic               busy
);

  localparam logic [CMD_W-1:0] NOP        = CMD_W'(0);
  localparam logic [CMD_W-1:0] CONFIG     = CMD_W'(1);
  localparam logic [CMD_W-1:0] ACK        = CMD_W'(2);
  localparam logic [CMD_W-1:0] LOAD       = CMD_W'(3);
  localparam logic [CMD_W-1:0] START_SORT = CMD_W'(4);
  localparam logic [CMD_W-1:0] SORT_DONE  = CMD_W'(5);
  localparam logic [CMD_W-1:0] ERR        = CMD_W'(6);

  typedef enum logic [1:0] {IDLE, CFG_WAIT, READY, SORT_WAIT} state_t;

  function automatic logic [AXIS_W-1:0] axis_of(input logic [DEPTH_W-1:0] d);
    return AXIS_W'(int'(d) % DIM);
  endfunction

  function automatic logic [COORD_W-1:0] coord_at(input logic [DATA_W-1:0] p,
                                                  input logic [AXIS_W-1:0] a);
    return p[int'(a)*COORD_W +: COORD_W];
  endfunction

  state_t              state_q, state_d;
  logic [CMD_W-1:0]    cmd_top_q, cmd_top_d, cmd_left_q, cmd_left_d, cmd_right_q, cmd_right_d;
  logic [DATA_W-1:0]   dat_top_q, dat_top_d, dat_left_q, dat_left_d, dat_right_q, dat_right_d;
  logic [DATA_W-1:0]   point_q, point_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic [AXIS_W-1:0]   axis_q, axis_d;
  logic                leaf_q, leaf_d, order_q, order_d;
  logic                ack_l_q, ack_l_d, ack_r_q, ack_r_d;
  logic                done_l_q, done_l_d, done_r_q, done_r_d;
  logic [COORD_W-1:0]  lco_q, lco_d, rco_q, rco_d;

  logic [DEPTH_W-1:0]  cfg_depth, cfg_max, cfg_child_depth;
  logic [DATA_W-1:0]   cfg_child_data;
  logic [COORD_W-1:0]  own_coord;
  logic                take_cfg;

  assign cfg_depth       = data_from_top[DEPTH_W-1:0];
  assign cfg_max         = data_from_top[2*DEPTH_W-1:DEPTH_W];
  assign cfg_child_depth = cfg_depth + DEPTH_W'(1);
  assign own_coord       = coord_at(point_q, axis_q);
  assign take_cfg        = (state_q == IDLE || state_q == READY) && command_from_top == CONFIG;

  always_comb begin
    cfg_child_data = '0;
    cfg_child_data[DEPTH_W-1:0]         = cfg_child_depth;
    cfg_child_data[2*DEPTH_W-1:DEPTH_W] = cfg_max;
  end

`ifdef KD_NODE_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [WD_W-1:0] wd_q, wd_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT ^ 32'(ERR);
`endif

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    axis_d      = axis_q;
    leaf_d      = leaf_q;
    order_d     = order_q;
    point_d     = point_q;
    ack_l_d     = ack_l_q;
    ack_r_d     = ack_r_q;
    done_l_d    = done_l_q;
    done_r_d    = done_r_q;
    lco_d       = lco_q;
    rco_d       = rco_q;
    cmd_top_d   = NOP;
    cmd_left_d  = NOP;
    cmd_right_d = NOP;
    dat_top_d   = '0;
    dat_left_d  = '0;
    dat_right_d = '0;
    case (state_q)
      CFG_WAIT: begin
        if (command_from_left == ACK)  ack_l_d = 1'b1;
        if (command_from_right == ACK) ack_r_d = 1'b1;
        if (ack_l_d && ack_r_d) begin
          cmd_top_d = ACK;
          ack_l_d   = 1'b0;
          ack_r_d   = 1'b0;
          state_d   = READY;
        end
      end
      READY: begin
        if (command_from_top == LOAD) begin
          point_d = data_from_top;
        end else if (command_from_top == START_SORT) begin
          if (leaf_q) begin
            cmd_top_d = SORT_DONE;
            dat_top_d = point_q;
            order_d   = 1'b1;
          end else begin
            cmd_left_d  = START_SORT;
            cmd_right_d = START_SORT;
            dat_left_d  = data_from_top;
            dat_right_d = data_from_top;
            state_d     = SORT_WAIT;
          end
        end
      end
      SORT_WAIT: begin
        // Only the first SORT_DONE from each child is kept.
        if (command_from_left == SORT_DONE && !done_l_q) begin
          done_l_d = 1'b1;
          lco_d    = coord_at(data_from_left, axis_q);
        end
        if (command_from_right == SORT_DONE && !done_r_q) begin
          done_r_d = 1'b1;
          rco_d    = coord_at(data_from_right, axis_q);
        end
        if (done_l_d && done_r_d) begin
          order_d   = (lco_d <= own_coord) && (rco_d >= own_coord);
          cmd_top_d = SORT_DONE;
          dat_top_d = point_q;
          done_l_d  = 1'b0;
          done_r_d  = 1'b0;
          state_d   = READY;
        end
      end
      default: ;
    endcase
    if (take_cfg) begin
      depth_d  = cfg_depth;
      axis_d   = axis_of(cfg_depth);
      leaf_d   = (cfg_depth == cfg_max);
      ack_l_d  = 1'b0;
      ack_r_d  = 1'b0;
      done_l_d = 1'b0;
      done_r_d = 1'b0;
      if (cfg_depth == cfg_max) begin
        cmd_top_d = ACK;
        state_d   = READY;
      end else begin
        cmd_left_d  = CONFIG;
        cmd_right_d = CONFIG;
        dat_left_d  = cfg_child_data;
        dat_right_d = cfg_child_data;
        state_d     = CFG_WAIT;
      end
    end
`ifdef KD_NODE_TIMEOUT_EN
    wd_d = wd_q;
    if (state_q == CFG_WAIT || state_q == SORT_WAIT) begin
      wd_d = wd_q + WD_W'(1);
      // A stalled or failing child aborts the whole wait back to IDLE.
      if (wd_q == WD_W'(TIMEOUT - 1) || command_from_left == ERR || command_from_right == ERR) begin
        cmd_top_d = ERR;
        dat_top_d = '0;
        ack_l_d   = 1'b0;
        ack_r_d   = 1'b0;
        done_l_d  = 1'b0;
        done_r_d  = 1'b0;
        state_d   = IDLE;
      end
    end
    if (state_d != state_q) wd_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_top_q   <= NOP;
      cmd_left_q  <= NOP;
      cmd_right_q <= NOP;
      dat_top_q   <= '0;
      dat_left_q  <= '0;
      dat_right_q <= '0;
      point_q     <= '0;
      depth_q     <= '0;
      axis_q      <= '0;
      leaf_q      <= 1'b0;
      order_q     <= 1'b0;
      ack_l_q     <= 1'b0;
      ack_r_q     <= 1'b0;
      done_l_q    <= 1'b0;
      done_r_q    <= 1'b0;
      lco_q       <= '0;
      rco_q       <= '0;
`ifdef KD_NODE_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_top_q   <= cmd_top_d;
      cmd_left_q  <= cmd_left_d;
      cmd_right_q <= cmd_right_d;
      dat_top_q   <= dat_top_d;
      dat_left_q  <= dat_left_d;
      dat_right_q <= dat_right_d;
      point_q     <= point_d;
      depth_q     <= depth_d;
      axis_q      <= axis_d;
      leaf_q      <= leaf_d;
      order_q     <= order_d;
      ack_l_q     <= ack_l_d;
      ack_r_q     <= ack_r_d;
      done_l_q    <= done_l_d;
      done_r_q    <= done_r_d;
      lco_q       <= lco_d;
      rco_q       <= rco_d;
`ifdef KD_NODE_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign command_to_top   = cmd_top_q;
  assign command_to_left  = cmd_left_q;
  assign command_to_right = cmd_right_q;
  assign data_to_top      = dat_top_q;
  assign data_to_left     = dat_left_q;
  assign data_to_right    = dat_right_q;
  assign depth            = depth_q;
  assign axis             = axis_q;
  assign is_leaf          = leaf_q;
  assign order_ok         = order_q;
  assign busy             = (state_q == CFG_WAIT) || (state_q == SORT_WAIT);

endmodule

// File: tb/tb_kd_node_ctrl.sv
// Randomized self-checking bench for kd_node_ctrl against a transaction-level node model.
module tb_kd_node_ctrl;
  localparam int DIM = 2, COORD_W = 16, DEPTH_W = 4, CMD_W = 3;
  localparam int DATA_W = DIM * COORD_W;
  localparam logic [CMD_W-1:0] NOP = 0, CONFIG = 1, ACK = 2, LOAD = 3, START = 4, DONE = 5, ERR = 6;

  logic clk = 1'b0, rst = 1'b1;
  logic [CMD_W-1:0]   cft = '0, cfl = '0, cfr = '0;
  logic [DATA_W-1:0]  dft = '0, dfl = '0, dfr = '0;
  logic [CMD_W-1:0]   ctt, ctl, ctr;
  logic [DATA_W-1:0]  dtt, dtl, dtr;
  logic [DEPTH_W-1:0] depth;
  logic [0:0]         axis;
  logic               is_leaf, order_ok, busy;

  kd_node_ctrl #(.DIM(DIM), .COORD_W(COORD_W), .DEPTH_W(DEPTH_W), .CMD_W(CMD_W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .command_from_top(cft), .command_from_left(cfl), .command_from_right(cfr),
    .data_from_top(dft), .data_from_left(dfl), .data_from_right(dfr),
    .command_to_top(ctt), .command_to_left(ctl), .command_to_right(ctr),
    .data_to_top(dtt), .data_to_left(dtl), .data_to_right(dtr),
    .depth(depth), .axis(axis), .is_leaf(is_leaf), .order_ok(order_ok), .busy(busy));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  // Reference node state, kept as plain numbers.
  int unsigned m_depth = 0, m_point[DIM];
  bit m_leaf = 0, m_order = 0, m_busy = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] pack_point();
    logic [DATA_W-1:0] v = '0;
    for (int i = 0; i < DIM; i++) v[i*COORD_W +: COORD_W] = COORD_W'(m_point[i]);
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] cfg_payload(input int unsigned d, input int unsigned mx);
    logic [DATA_W-1:0] v = '0;
    v[DEPTH_W-1:0]         = DEPTH_W'(d % (1 << DEPTH_W));
    v[2*DEPTH_W-1:DEPTH_W] = DEPTH_W'(mx);
    return v;
  endfunction

  // Present one cycle of inputs, then look just after the capturing edge.
  task automatic cyc(input logic [CMD_W-1:0] ct, input logic [DATA_W-1:0] pt,
                     input logic [CMD_W-1:0] cl, input logic [DATA_W-1:0] pl,
                     input logic [CMD_W-1:0] cr, input logic [DATA_W-1:0] pr);
    cft = ct; dft = pt; cfl = cl; dfl = pl; cfr = cr; dfr = pr;
    @(posedge clk); #1;
    cft = NOP; cfl = NOP; cfr = NOP; dft = '0; dfl = '0; dfr = '0;
  endtask

  task automatic expect_outs(input string tag,
                             input logic [CMD_W-1:0] et, input logic [DATA_W-1:0] edt,
                             input logic [CMD_W-1:0] el, input logic [DATA_W-1:0] edl,
                             input logic [CMD_W-1:0] er, input logic [DATA_W-1:0] edr);
    chk({tag, ".cmd_top"}, ctt, et);
    chk({tag, ".data_top"}, dtt, edt);
    chk({tag, ".cmd_left"}, ctl, el);
    chk({tag, ".data_left"}, dtl, edl);
    chk({tag, ".cmd_right"}, ctr, er);
    chk({tag, ".data_right"}, dtr, edr);
  endtask

  task automatic expect_state(input string tag);
    chk({tag, ".depth"}, depth, m_depth);
    chk({tag, ".axis"}, axis, m_depth % DIM);
    chk({tag, ".is_leaf"}, is_leaf, m_leaf);
    chk({tag, ".order_ok"}, order_ok, m_order);
    chk({tag, ".busy"}, busy, m_busy);
  endtask

  task automatic model_reset();
    m_depth = 0; m_leaf = 0; m_order = 0; m_busy = 0;
    for (int i = 0; i < DIM; i++) m_point[i] = 0;
  endtask

  task automatic do_config(input int unsigned d, input int unsigned mx, input int dl, input int dr);
    logic [CMD_W-1:0] junk[3] = '{NOP, LOAD, DONE};
    logic [CMD_W-1:0] ct, cl, cr;
    logic [DATA_W-1:0] pt;
    int last;
    cyc(CONFIG, cfg_payload(d, mx), NOP, '0, NOP, '0);
    m_depth = d; m_leaf = (d == mx);
    if (m_leaf) begin
      m_busy = 0;
      expect_outs("cfg_leaf", ACK, '0, NOP, '0, NOP, '0);
      expect_state("cfg_leaf");
      return;
    end
    m_busy = 1;
    expect_outs("cfg_fwd", NOP, '0, CONFIG, cfg_payload(d + 1, mx), CONFIG, cfg_payload(d + 1, mx));
    expect_state("cfg_fwd");
    last = (dl > dr) ? dl : dr;
    for (int c = 0; c <= last; c++) begin
      ct = ($urandom % 2) ? LOAD : NOP;
      pt = $urandom;
      cl = (c == dl) ? ACK : junk[$urandom % 3];
      cr = (c == dr) ? ACK : junk[$urandom % 3];
      cyc(ct, pt, cl, $urandom, cr, $urandom);
      if (c == last) begin
        m_busy = 0;
        expect_outs("cfg_ack", ACK, '0, NOP, '0, NOP, '0);
      end else begin
        expect_outs("cfg_wait", NOP, '0, NOP, '0, NOP, '0);
      end
      expect_state("cfg_wait");
    end
  endtask

  task automatic do_load(input int unsigned p0, input int unsigned p1);
    logic [DATA_W-1:0] v;
    m_point[0] = p0 % (1 << COORD_W);
    m_point[1] = p1 % (1 << COORD_W);
    v = pack_point();
    cyc(LOAD, v, NOP, '0, NOP, '0);
    expect_outs("load", NOP, '0, NOP, '0, NOP, '0);
    expect_state("load");
  endtask

  task automatic do_sort(input int unsigned lc, input int unsigned rc, input int dl, input int dr);
    logic [CMD_W-1:0] junk[3] = '{NOP, ACK, CONFIG};
    logic [CMD_W-1:0] cl, cr;
    logic [DATA_W-1:0] pl, pr;
    int last, ax;
    cyc(START, '0, NOP, '0, NOP, '0);
    if (m_leaf) begin
      m_order = 1;
      expect_outs("sort_leaf", DONE, pack_point(), NOP, '0, NOP, '0);
      expect_state("sort_leaf");
      return;
    end
    m_busy = 1;
    expect_outs("sort_fwd", NOP, '0, START, '0, START, '0);
    expect_state("sort_fwd");
    ax = m_depth % DIM;
    last = (dl > dr) ? dl : dr;
    for (int c = 0; c <= last; c++) begin
      pl = $urandom; pr = $urandom;
      pl[ax*COORD_W +: COORD_W] = COORD_W'(lc);
      pr[ax*COORD_W +: COORD_W] = COORD_W'(rc);
      cl = (c == dl) ? DONE : junk[$urandom % 3];
      cr = (c == dr) ? DONE : junk[$urandom % 3];
      cyc(($urandom % 2) ? START : LOAD, $urandom, cl, pl, cr, pr);
      if (c == last) begin
        m_busy = 0;
        m_order = (lc <= m_point[ax]) && (rc >= m_point[ax]);
        expect_outs("sort_done", DONE, pack_point(), NOP, '0, NOP, '0);
      end else begin
        expect_outs("sort_wait", NOP, '0, NOP, '0, NOP, '0);
      end
      expect_state("sort_wait");
    end
  endtask

  function automatic int unsigned near(input int unsigned own);
    case ($urandom % 4)
      0: return own;
      1: return (own + 65535) % 65536;
      2: return (own + 1) % 65536;
      default: return $urandom % 65536;
    endcase
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    expect_outs("reset", NOP, '0, NOP, '0, NOP, '0);
    expect_state("reset");
    rst = 1'b0;

    // Leaf configuration: depth 3 of 3 lands on axis 1.
    do_config(3, 3, 0, 0);
    chk("leaf_axis", axis, 1);
    // Skewed acks (left at t+4, right at t+9), then simultaneous acks.
    do_config(0, 2, 3, 8);
    do_config(0, 2, 2, 2);
    do_config(1, 2, 0, 4);

    // Split ordering on axis 0 around point (50,20).
    do_config(0, 2, 1, 0);
    do_load(50, 20);
    do_sort(40, 60, 1, 2);
    chk("sort_in_order", order_ok, 1);
    do_sort(70, 60, 0, 0);
    chk("sort_out_of_order", order_ok, 0);

    // Reset while waiting for configuration acks.
    cyc(CONFIG, cfg_payload(0, 2), NOP, '0, NOP, '0);
    expect_outs("pre_rst", NOP, '0, CONFIG, cfg_payload(1, 2), CONFIG, cfg_payload(1, 2));
    rst = 1'b1;
    cyc(NOP, '0, NOP, '0, NOP, '0);
    rst = 1'b0;
    model_reset();
    expect_outs("mid_rst", NOP, '0, NOP, '0, NOP, '0);
    expect_state("mid_rst");
    cyc(NOP, '0, ACK, '0, NOP, '0);
    cyc(NOP, '0, NOP, '0, ACK, '0);
    expect_outs("post_rst", NOP, '0, NOP, '0, NOP, '0);
    expect_state("post_rst");

`ifdef KD_NODE_TIMEOUT_EN
    cyc(CONFIG, cfg_payload(0, 2), NOP, '0, NOP, '0);
    m_depth = 0; m_leaf = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(NOP, '0, NOP, '0, NOP, '0);
      if (c == 7) expect_outs("wd_err", ERR, '0, NOP, '0, NOP, '0);
      else        expect_outs("wd_wait", NOP, '0, NOP, '0, NOP, '0);
    end
    chk("wd_busy", busy, 0);
    cyc(NOP, '0, ACK, '0, ACK, '0);
    expect_outs("wd_idle", NOP, '0, NOP, '0, NOP, '0);
`else
    cyc(CONFIG, cfg_payload(0, 2), NOP, '0, NOP, '0);
    m_depth = 0; m_leaf = 0; m_busy = 1;
    cyc(NOP, '0, ERR, '0, NOP, '0);
    expect_outs("err_ignored", NOP, '0, NOP, '0, NOP, '0);
    expect_state("err_ignored");
    cyc(NOP, '0, ACK, '0, ACK, '0);
    m_busy = 0;
    expect_outs("err_then_ack", ACK, '0, NOP, '0, NOP, '0);
`endif

    for (int it = 0; it < 30; it++) begin
      int unsigned mx, d;
      mx = $urandom_range(6, 0);
      d  = $urandom_range(mx, 0);
      do_config(d, mx, $urandom_range(5, 0), $urandom_range(5, 0));
      do_load($urandom, $urandom);
      for (int s = 0; s < 2; s++)
        do_sort(near(m_point[m_depth % DIM]), near(m_point[m_depth % DIM]),
                $urandom_range(4, 0), $urandom_range(4, 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/kd_node_ctrl.md
# kd_node_ctrl

Parametrised k-d tree node controller with D-dimensional points, runtime depth/time-to-live configuration and sticky child handshakes. One instance sits at each tree position. It links to its parent (top) and two children (left/right) through command/data buses, and propagates configuration and sort commands down the tree. It reports acknowledgements upward and checks its children's split ordering on the node's axis.

## Interface
Parameters:
- DIM, 2, point dimensions (≥1)
- COORD_W, 16, unsigned coordinate width
- DEPTH_W, 4, depth / max-depth field width
- CMD_W, 3, command code width
- TIMEOUT, 1023, watchdog limit in cycles (used only with KD_NODE_TIMEOUT_EN)

Derived: DATA_W = DIM*COORD_W (must be ≥ 2*DEPTH_W).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- command_from_top/left/right  in  CMD_W  incoming command, single-cycle pulse; 0 = NOP
- data_from_top/left/right  in  DATA_W  payload; valid only when the matching command is non-NOP
- command_to_top/left/right  out  CMD_W  registered outgoing command
- data_to_top/left/right  out  DATA_W  registered payload
- depth  out  DEPTH_W  latched node depth
- axis  out  $clog2(DIM) (min 1)  split axis = depth mod DIM
- is_leaf  out  1  depth == max_depth
- order_ok  out  1  result of the last ordering check
- busy  out  1  FSM not in IDLE/READY

## Operation
- Command codes: NOP=0, CONFIG=1, ACK=2, LOAD=3, START_SORT=4, SORT_DONE=5, ERR=6.
- CONFIG payload layout: data[DEPTH_W-1:0] = depth; data[2*DEPTH_W-1:DEPTH_W] = max_depth.
- States: IDLE, CFG_WAIT, READY, SORT_WAIT.
- IDLE + CONFIG from top:
  - latch depth, max_depth and axis;
  - if leaf, send ACK to top, go READY;
  - else send CONFIG to both children with depth+1 (max_depth unchanged), go CFG_WAIT.
  - All other commands in IDLE are ignored.
- CFG_WAIT:
  - sticky flags ack_l/ack_r are set by ACK from the matching child; acks may arrive in any order or together.
  - When both flags are set, send ACK to top, clear the flags, go READY.
- READY:
  - LOAD from top latches point ← data_from_top; no response.
  - START_SORT, leaf: send SORT_DONE to top with data = point; order_ok ← 1.
  - START_SORT, non-leaf: forward START_SORT to both children, go SORT_WAIT.
  - CONFIG from top re-enters the IDLE CONFIG behaviour (reconfiguration).
- SORT_WAIT:
  - latch each child's SORT_DONE payload coordinate on the node's axis, using sticky flags.
  - When both are latched, set order_ok ← (left_coord ≤ own_coord) && (right_coord ≥ own_coord), unsigned compare.
  - Then send SORT_DONE to top with data = point, go READY.
- Unexpected commands (wrong source, wrong code for the state) are ignored and do not alter any flag.
- Top commands arriving in CFG_WAIT or SORT_WAIT are ignored.
- Depth arithmetic is DEPTH_W bits and wraps. Reaching wrap is legal only if max_depth < 2^DEPTH_W − 1; the bench keeps max_depth within range.

## Timing
- All outputs are registered; each command output is a single-cycle pulse, and NOP/0 otherwise.
- Latencies:
  - top command at cycle t → child/top response at t+1;
  - final child ACK/SORT_DONE at cycle u → top response at u+1.
- Reset values:
  - all command_to_* = NOP;
  - data_to_* = 0, depth = 0, axis = 0, is_leaf = 0, order_ok = 0, busy = 0;
  - point = 0, all flags cleared, state IDLE.
- Reset mid-handshake aborts immediately. No pending response is emitted after reset deasserts.
- Payload on data_to_* is held with its command pulse only; it is zeroed otherwise.

## Configuration
- KD_NODE_TIMEOUT_EN defined:
  - a watchdog counter runs in CFG_WAIT/SORT_WAIT and clears on entry;
  - on reaching TIMEOUT cycles, the node sends ERR to top, clears its flags and goes IDLE (busy = 0);
  - ERR from a child during a wait is treated the same way on the next cycle.
- KD_NODE_TIMEOUT_EN undefined: no counter, waits are unbounded, and ERR inputs are ignored.

## Test plan
- Leaf config: CONFIG from top with depth=3, max_depth=3, DIM=2 → ACK to top at t+1; is_leaf=1, axis=1.
- Internal config with skewed acks: CONFIG depth=0, max_depth=2 → CONFIG depth=1 to both children at t+1. Left ACK at t+4, right ACK at t+9 → top ACK at t+10 only.
- Simultaneous acks: both children ACK in the same cycle → exactly one top ACK the next cycle; flags cleared.
- Sort check: LOAD point=(50,20), depth=0. Children SORT_DONE x=40 and x=60 → order_ok=1, SORT_DONE data=(50,20). Repeat with left x=70 → order_ok=0.
- Reset mid-operation: rst asserted in CFG_WAIT, then left ACK → no top ACK; all outputs at reset values.
- With KD_NODE_TIMEOUT_EN and TIMEOUT=8: CONFIG, no child acks → ERR to top 8 cycles after entering CFG_WAIT, then IDLE.
